// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: ping-pong line-buffer controller for a 2^ADDR_WIDTH x DATA_WIDTH
// simple dual-port RAM with a one-cycle read latency. Incoming lines go into
// alternating RAM halves. Each completed line is replayed through a 2-entry skid
// buffer to a ready/valid consumer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/data/last  pixel input stream (no back-pressure)
//   ram_wr_*            registered RAM write port
//   ram_rd_addr         RAM read address (combinational from counters)
//   ram_rd_data         RAM read data, valid one clock after the address
//   out_valid/data/last replayed pixel stream; out_ready is downstream accept
//   ovf                 sticky: pixel dropped, no free bank
//   trunc               sticky: line longer than MAX_LINE was cut
module line_buf_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LINE   = 2**(ADDR_WIDTH-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  ovf,
  output logic                  trunc
);

  localparam int unsigned CNT_W = ADDR_WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LINE - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Per-bank state and index of the final pixel (length - 1)
  logic [1:0][1:0]       bank_st;
  logic [1:0][1:0]       bank_nxt;
  logic [1:0][CNT_W-1:0] last_idx;

  logic             wr_bank;
  logic [CNT_W-1:0] wr_cnt;
  logic             discard;

  logic             rd_bank;
  logic [CNT_W-1:0] rd_cnt;
  logic             inflight;
  logic             inflight_last;

  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic [DATA_WIDTH-1:0] slot_data;
  logic                  slot_last;

  logic       pop;
  logic       push;
  logic       issue;
  logic       rd_final;
  logic       accept;
  logic       wr_drop;
  logic       wr_close;
  logic [2:0] pending;

  assign ram_rd_addr = {rd_bank, rd_cnt};

  // Next-state: handshake, read issue, write accept and bank transitions
  always_comb begin
    pop      = out_valid & out_ready;
    push     = inflight;
    // Entries that will still be held after this cycle's pop; a FULL bank is
    // read in the same cycle it turns DRAINING so replay starts right away.
    pending  = 3'(occ) + 3'(inflight) - 3'(pop);
    issue    = (bank_st[rd_bank] != ST_EMPTY) && (pending < 3'd2);
    rd_final = (rd_cnt == last_idx[rd_bank]);
    accept   = in_valid && !discard && (bank_st[wr_bank] == ST_EMPTY);
    wr_drop  = in_valid && !discard && (bank_st[wr_bank] != ST_EMPTY);
    wr_close = accept && (in_last || (wr_cnt == CNT_MAX));

    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase

    // Reader and writer never touch the same bank in one cycle: the writer
    // only closes an EMPTY bank, the reader only acts on a non-EMPTY one.
    bank_nxt = bank_st;
    if (issue) begin
      bank_nxt[rd_bank] = rd_final ? ST_EMPTY : ST_DRAIN;
    end else if (bank_st[rd_bank] == ST_FULL) begin
      bank_nxt[rd_bank] = ST_DRAIN;
    end
    if (wr_close) begin
      bank_nxt[wr_bank] = ST_FULL;
    end
  end

  // Bank state register
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st <= {ST_EMPTY, ST_EMPTY};
    end else begin
      bank_st <= bank_nxt;
    end
  end

  // Write side: RAM write port, line counter, discard and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      discard     <= 1'b0;
      last_idx    <= '0;
      ovf         <= 1'b0;
      trunc       <= 1'b0;
    end else begin
      ram_wr_en <= accept;
      if (accept) begin
        ram_wr_addr <= {wr_bank, wr_cnt};
        ram_wr_data <= in_data;
      end
      if (wr_close) begin
        last_idx[wr_bank] <= wr_cnt;
        wr_bank           <= ~wr_bank;
        wr_cnt            <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      // A forced close drops the rest of the line up to and including in_last
      if (wr_close && !in_last) begin
        trunc   <= 1'b1;
        discard <= 1'b1;
      end else if (in_valid && discard && in_last) begin
        discard <= 1'b0;
      end
      if (wr_drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Read side: address counter and in-flight tag for the RAM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank       <= 1'b0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && rd_final;
      if (issue) begin
        if (rd_final) begin
          rd_bank <= ~rd_bank;
          rd_cnt  <= '0;
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Skid buffer: head is the output register, slot is the second entry
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      slot_data <= '0;
      slot_last <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != 2'd0);
      if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        out_data <= ram_rd_data;
        out_last <= inflight_last;
      end else if (pop && (occ == 2'd2)) begin
        out_data <= slot_data;
        out_last <= slot_last;
      end
      if (push && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
        slot_data <= ram_rd_data;
        slot_last <= inflight_last;
      end
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: self-checking bench for line_buf_ctrl with a RAM model and
// a line-level reference model compared against the DUT on every cycle.
module tb_line_buf_ctrl;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = AW - 1;
  localparam int          ML = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_wr_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          ovf;
  logic          trunc;

  always #5 clk = ~clk;

  line_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LINE(ML)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .ovf(ovf), .trunc(trunc)
  );

  // RAM: registered address, unregistered data output
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [AW-1:0] rd_addr_q;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_addr_q <= ram_rd_addr;
  end
  assign ram_rd_data = mem[rd_addr_q];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Out-ready driver: fixed level or 50% random
  bit rand_ready = 1'b0;
  bit ready_fix  = 1'b1;
  always @(negedge clk) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;

  // Reference model: lines as pixel queues; reader stays at most two pixels
  // ahead of the consumer, data appears two cycles after its read is issued,
  // and a bank is busy from line close until its last pixel is read.
  typedef struct { logic [DW-1:0] d; bit l; bit b; } aent_t;
  typedef struct { logic [DW-1:0] d; bit l; int vis; } pent_t;
  aent_t         avail[$];
  pent_t         pipe[$];
  logic [DW-1:0] cur[$];
  bit            busy[2];
  bit            m_wbank, m_disc, m_ovf, m_trunc;
  int            m_widx;
  bit            e_wr_en;
  logic [AW-1:0] e_wr_addr;
  logic [DW-1:0] e_wr_data;
  int            cyc = 0;
  int            last_in_cyc = 0;
  int            first_v_cyc = -1;

  // Accepted outputs with their accept edge
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  int            got_c[$];
  bit            prev_v = 1'b0;
  logic [DW-1:0] prev_d;
  bit            prev_l;

  always @(posedge clk) begin : model
    bit    pop, iss, do_close, was_rst, ev, cb;
    aent_t a;
    pent_t p;
    cyc++;
    was_rst  = rst;
    do_close = 1'b0;
    cb       = 1'b0;
    if (!rst && prev_v && out_ready) begin
      got_d.push_back(prev_d);
      got_l.push_back(prev_l);
      got_c.push_back(cyc);
    end
    if (rst) begin
      avail.delete(); pipe.delete(); cur.delete();
      busy[0] = 0; busy[1] = 0;
      m_wbank = 0; m_widx = 0; m_disc = 0; m_ovf = 0; m_trunc = 0;
      e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0;
    end else begin
      pop = (pipe.size() > 0) && (pipe[0].vis <= cyc - 1) && out_ready;
      iss = (avail.size() > 0) && ((pipe.size() - int'(pop)) < 2);
      e_wr_en = 0;
      if (in_valid) begin
        if (m_disc) begin
          if (in_last) m_disc = 0;
        end else if (busy[m_wbank]) begin
          m_ovf = 1;
        end else begin
          e_wr_en   = 1;
          e_wr_addr = {m_wbank, CW'(m_widx)};
          e_wr_data = in_data;
          cur.push_back(in_data);
          if (in_last) last_in_cyc = cyc;
          if (in_last || m_widx == ML - 1) begin
            if (!in_last) begin m_trunc = 1; m_disc = 1; end
            do_close = 1;
            cb = m_wbank;
            busy[m_wbank] = 1;
            m_wbank = ~m_wbank;
            m_widx = 0;
          end else begin
            m_widx++;
          end
        end
      end
      if (pop) void'(pipe.pop_front());
      if (iss) begin
        a = avail.pop_front();
        p.d = a.d; p.l = a.l; p.vis = cyc + 1;
        pipe.push_back(p);
        if (a.l) busy[a.b] = 0;
      end
      if (do_close) begin
        for (int i = 0; i < cur.size(); i++) begin
          a.d = cur[i]; a.l = (i == cur.size() - 1); a.b = cb;
          avail.push_back(a);
        end
        cur.delete();
      end
    end
    #1;
    ev = (pipe.size() > 0) && (pipe[0].vis <= cyc);
    chk("out_valid", int'(out_valid), int'(ev));
    if (ev) begin
      chk("out_data", int'(out_data), int'(pipe[0].d));
      chk("out_last", int'(out_last), int'(pipe[0].l));
    end
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("trunc", int'(trunc), int'(m_trunc));
    chk("ram_wr_en", int'(ram_wr_en), int'(e_wr_en));
    if (e_wr_en) begin
      chk("ram_wr_addr", int'(ram_wr_addr), int'(e_wr_addr));
      chk("ram_wr_data", int'(ram_wr_data), int'(e_wr_data));
    end
    if (was_rst) begin
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_wr_addr", int'(ram_wr_addr), 0);
      chk("rst_wr_data", int'(ram_wr_data), 0);
    end
    prev_v = out_valid; prev_d = out_data; prev_l = out_last;
    if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
  end

  task automatic pix(input bit v, input logic [DW-1:0] d, input bit l);
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) pix(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_got();
    got_d.delete(); got_l.delete(); got_c.delete();
    first_v_cyc = -1;
  endtask

  task automatic wait_got(input string nm, input int n, input int budget);
    int c = 0;
    while (got_d.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, got_d.size(), n);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int errs;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    int len;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_wr_en", int'(ram_wr_en), 0);

    // 1: ten-pixel line, free-running consumer
    clear_got();
    for (int i = 0; i < 10; i++) pix(1'b1, DW'(i), i == 9);
    idle(1);
    wait_got("t1_count", 10, 50);
    if (got_d.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("t1_data", int'(got_d[i]), i);
        chk("t1_last", int'(got_l[i]), int'(i == 9));
      end
      chk("t1_span", got_c[9] - got_c[0], 9);
    end
    chk("t1_latency", first_v_cyc - last_in_cyc, 2);
    chk("t1_ovf", int'(ovf), 0);
    chk("t1_trunc", int'(trunc), 0);

    // 2: three back-to-back full-length lines
    do_reset();
    clear_got();
    for (int ln = 0; ln < 3; ln++)
      for (int i = 0; i < ML; i++) pix(1'b1, DW'(i + 7 * ln), i == ML - 1);
    idle(1);
    wait_got("t2_count", 3 * ML, 4000);
    if (got_d.size() == 3 * ML) begin
      errs = 0;
      for (int k = 0; k < 3 * ML; k++) begin
        if (got_d[k] != DW'((k % ML) + 7 * (k / ML))) errs++;
        if (got_l[k] != ((k % ML) == ML - 1)) errs++;
      end
      chk("t2_errors", errs, 0);
      chk("t2_span", got_c[3 * ML - 1] - got_c[0], 3 * ML - 1);
    end
    chk("t2_ovf", int'(ovf), 0);

    // 3: over-long line is cut at MAX_LINE
    do_reset();
    clear_got();
    for (int i = 0; i < ML + 6; i++) pix(1'b1, DW'(i), i == ML + 5);
    idle(20);
    wait_got("t3_count", ML, 2000);
    idle(20);
    chk("t3_count_final", got_d.size(), ML);
    if (got_d.size() == ML) begin
      errs = 0;
      for (int i = 0; i < ML; i++) begin
        if (got_d[i] != DW'(i)) errs++;
        if (got_l[i] != (i == ML - 1)) errs++;
      end
      chk("t3_errors", errs, 0);
    end
    chk("t3_trunc", int'(trunc), 1);
    chk("t3_ovf", int'(ovf), 0);

    // 4: stalled consumer, third line has no free bank
    do_reset();
    ready_fix = 1'b0;
    clear_got();
    for (int ln = 1; ln <= 3; ln++)
      for (int i = 0; i < 4; i++) pix(1'b1, DW'(10 * ln + i), i == 3);
    idle(10);
    chk("t4_ovf", int'(ovf), 1);
    chk("t4_stalled", got_d.size(), 0);
    ready_fix = 1'b1;
    wait_got("t4_count", 8, 100);
    idle(10);
    chk("t4_count_final", got_d.size(), 8);
    if (got_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t4_data", int'(got_d[i]), (i < 4) ? 10 + i : 16 + i);
        chk("t4_last", int'(got_l[i]), int'(i == 3 || i == 7));
      end
    end

    // 5: random back-pressure over a 100-pixel line
    do_reset();
    clear_got();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      while ($urandom_range(0, 3) == 0) pix(1'b0, '0, 1'b0);
      d = DW'($urandom);
      exp_q.push_back(d);
      pix(1'b1, d, i == 99);
    end
    idle(1);
    wait_got("t5_count", 100, 2000);
    if (got_d.size() == 100) begin
      errs = 0;
      for (int i = 0; i < 100; i++) begin
        if (got_d[i] != exp_q[i]) errs++;
        if (got_l[i] != (i == 99)) errs++;
      end
      chk("t5_errors", errs, 0);
    end
    rand_ready = 1'b0;
    ready_fix  = 1'b1;

    // 6a: reset on the fifth pixel of a line
    do_reset();
    clear_got();
    for (int i = 1; i <= 4; i++) pix(1'b1, DW'(i), 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd5; in_last = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_rst_wr_en", int'(ram_wr_en), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    for (int i = 0; i < 16; i++) pix(1'b1, DW'(i), i == 15);
    idle(1);
    wait_got("t6a_count", 16, 100);
    idle(10);
    chk("t6a_count_final", got_d.size(), 16);
    if (got_d.size() == 16)
      for (int i = 0; i < 16; i++) chk("t6a_data", int'(got_d[i]), i);

    // 6b: reset while a line is draining
    for (int i = 0; i < 60; i++) pix(1'b1, DW'(200 + i), i == 59);
    idle(10);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6b_rst_valid", int'(out_valid), 0);
    clear_got();
    idle(10);
    chk("t6b_no_leftover", got_d.size(), 0);
    for (int i = 0; i < 20; i++) pix(1'b1, DW'(100 + i), i == 19);
    idle(1);
    wait_got("t6b_count", 20, 100);
    if (got_d.size() == 20) begin
      for (int i = 0; i < 20; i++) chk("t6b_data", int'(got_d[i]), 100 + i);
      chk("t6b_last", int'(got_l[19]), 1);
    end

    // 7: random lines, gaps and back-pressure against the model
    do_reset();
    rand_ready = 1'b1;
    for (int ln = 0; ln < 25; ln++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0) pix(1'b0, '0, 1'b0);
        pix(1'b1, DW'($urandom), i == len - 1);
      end
    end
    idle(1);
    rand_ready = 1'b0;
    ready_fix  = 1'b1;
    idle(200);
    chk("t7_drained", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
